// File: rtl/dkong_sound_pkg.sv
// Shared types and constants for the Donkey Kong sound-effect mixer.
// Pure definitions: no latency, no flow control.
package dkong_sound_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int ENV_W       = 8;
  localparam int DAC_SHIFT   = 7;
  localparam int WALK_SHIFT  = 4;
  localparam int JUMP_SHIFT  = 4;
  localparam int CRASH_SHIFT = 5;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PLAY = 1'b1
  } ch_state_t;

  // Sign-extend a 9-bit signed term to sample width and weight it by a left shift.
  function automatic logic signed [SAMPLE_W-1:0] scale_term(
    input logic signed [ENV_W:0] v,
    input int unsigned           sh
  );
    logic signed [SAMPLE_W-1:0] ext;
    ext = {{(SAMPLE_W-ENV_W-1){v[ENV_W]}}, v};
    return ext <<< sh;
  endfunction

endpackage

// File: rtl/dkong_sfx_channel.sv
// One analog-SFX voice: trigger edge detect, IDLE/PLAY FSM, decaying envelope, square or noise sign.
// State advances on the sample_tick edge; contribution is combinational from state; no backpressure.
module dkong_sfx_channel
  import dkong_sound_pkg::*;
#(
  parameter int HALF_PERIOD = 32,
  parameter int DECAY_DIV   = 16,
  parameter bit USE_NOISE   = 1'b0
) (
  input  logic                  soundclk,
  input  logic                  rst_n,
  input  logic                  i_sample_tick,
  input  logic                  i_trig,
  input  logic                  i_noise,
  output logic signed [ENV_W:0] o_contrib
);

  localparam int HP_W = $clog2(HALF_PERIOD + 1);
  localparam int DV_W = $clog2(DECAY_DIV + 1);
  localparam logic [HP_W-1:0]  HP_LAST = HP_W'(HALF_PERIOD - 1);
  localparam logic [DV_W-1:0]  DV_LAST = DV_W'(DECAY_DIV - 1);
  localparam logic [HP_W-1:0]  HP_ONE  = HP_W'(1);
  localparam logic [DV_W-1:0]  DV_ONE  = DV_W'(1);
  localparam logic [ENV_W-1:0] ENV_ONE = ENV_W'(1);

  ch_state_t         r_state, w_state_nxt;
  logic [ENV_W-1:0]  r_env, w_env_nxt;
  logic [DV_W-1:0]   r_decay_cnt, w_decay_nxt;
  logic [HP_W-1:0]   r_half_cnt, w_half_nxt;
  logic              r_sq, w_sq_nxt;
  logic              r_trig_prev;
  logic              w_rise;
  logic signed [ENV_W:0] w_mag;

  // History resets high so a trigger already asserted across reset is not an edge.
  assign w_rise = i_trig & ~r_trig_prev;

  always_ff @(posedge soundclk) begin
    if (!rst_n) begin
      r_state     <= CH_IDLE;
      r_env       <= '0;
      r_decay_cnt <= '0;
      r_half_cnt  <= '0;
      r_sq        <= 1'b0;
      r_trig_prev <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_env       <= w_env_nxt;
      r_decay_cnt <= w_decay_nxt;
      r_half_cnt  <= w_half_nxt;
      r_sq        <= w_sq_nxt;
      r_trig_prev <= i_trig;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_decay_nxt = r_decay_cnt;
    w_half_nxt  = r_half_cnt;
    w_sq_nxt    = r_sq;
    if (w_rise) begin
      w_state_nxt = CH_PLAY;
      w_env_nxt   = '1;
      w_decay_nxt = '0;
      w_half_nxt  = '0;
      w_sq_nxt    = 1'b1;
    end else if (r_state == CH_PLAY && i_sample_tick) begin
      if (r_decay_cnt == DV_LAST) begin
        w_decay_nxt = '0;
        w_env_nxt   = r_env - ENV_ONE;
        if (r_env == ENV_ONE) begin
          w_state_nxt = CH_IDLE;
        end
      end else begin
        w_decay_nxt = r_decay_cnt + DV_ONE;
      end
      if (USE_NOISE) begin
        w_sq_nxt = i_noise;
      end else if (r_half_cnt == HP_LAST) begin
        w_half_nxt = '0;
        w_sq_nxt   = ~r_sq;
      end else begin
        w_half_nxt = r_half_cnt + HP_ONE;
      end
    end
  end

  assign w_mag     = {1'b0, r_env};
  assign o_contrib = (r_state == CH_PLAY) ? (r_sq ? w_mag : -w_mag) : '0;

endmodule

// File: rtl/dkong_sfx_mixer.sv
// Mixes DAC plus walk/jump/crash voices into one signed sample; tick at T -> sample_out at T+2.
// Single output register: sample_valid holds until accepted, a newer sample overwrites and sets sticky overrun.
module dkong_sfx_mixer
  import dkong_sound_pkg::*;
#(
  parameter int WALK_HALF_PERIOD = 32,
  parameter int JUMP_HALF_PERIOD = 12,
  parameter int WALK_DECAY_DIV   = 16,
  parameter int JUMP_DECAY_DIV   = 64,
  parameter int CRASH_DECAY_DIV  = 128
) (
  input  logic                       soundclk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic [7:0]                 dac_in,
  input  logic                       dac_mute,
  input  logic                       walk_in,
  input  logic                       jump_in,
  input  logic                       crash_in,
  input  logic                       noise_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun
);

  logic signed [ENV_W:0]    w_walk, w_jump, w_crash;
  logic signed [ENV_W:0]    w_dac_term;
  logic signed [SAMPLE_W-1:0] w_mix;

  logic signed [ENV_W:0]    r_dac_term;
  logic                     r_tick_d1;
  logic                     r_mix_vld;
  logic signed [SAMPLE_W-1:0] r_mix;
  logic signed [SAMPLE_W-1:0] r_sample_out;
  logic                     r_sample_valid;
  logic                     r_overrun;

  dkong_sfx_channel #(
    .HALF_PERIOD (WALK_HALF_PERIOD),
    .DECAY_DIV   (WALK_DECAY_DIV),
    .USE_NOISE   (1'b0)
  ) u_walk (
    .soundclk      (soundclk),
    .rst_n         (rst_n),
    .i_sample_tick (sample_tick),
    .i_trig        (walk_in),
    .i_noise       (noise_in),
    .o_contrib     (w_walk)
  );

  dkong_sfx_channel #(
    .HALF_PERIOD (JUMP_HALF_PERIOD),
    .DECAY_DIV   (JUMP_DECAY_DIV),
    .USE_NOISE   (1'b0)
  ) u_jump (
    .soundclk      (soundclk),
    .rst_n         (rst_n),
    .i_sample_tick (sample_tick),
    .i_trig        (jump_in),
    .i_noise       (noise_in),
    .o_contrib     (w_jump)
  );

  dkong_sfx_channel #(
    .HALF_PERIOD (1),
    .DECAY_DIV   (CRASH_DECAY_DIV),
    .USE_NOISE   (1'b1)
  ) u_crash (
    .soundclk      (soundclk),
    .rst_n         (rst_n),
    .i_sample_tick (sample_tick),
    .i_trig        (crash_in),
    .i_noise       (noise_in),
    .o_contrib     (w_crash)
  );

  // dac_in - 128 is dac_in with the MSB inverted, then sign-extended to 9 bits.
  assign w_dac_term = dac_mute ? '0 : {~dac_in[7], ~dac_in[7], dac_in[6:0]};

  assign w_mix = scale_term(r_dac_term, DAC_SHIFT)
               + scale_term(w_walk,     WALK_SHIFT)
               + scale_term(w_jump,     JUMP_SHIFT)
               + scale_term(w_crash,    CRASH_SHIFT);

  always_ff @(posedge soundclk) begin
    if (!rst_n) begin
      r_dac_term     <= '0;
      r_tick_d1      <= 1'b0;
      r_mix_vld      <= 1'b0;
      r_mix          <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_tick_d1 <= sample_tick;
      r_mix_vld <= r_tick_d1;
      if (sample_tick) begin
        r_dac_term <= w_dac_term;
      end
      if (r_tick_d1) begin
        r_mix <= w_mix;
      end
      if (r_mix_vld) begin
        r_sample_out   <= r_mix;
        r_sample_valid <= 1'b1;
        if (r_sample_valid && !sample_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (sample_ready) begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;

endmodule

// File: doc/dkong_sfx_mixer.md
DKONG_SFX_MIXER -- requirements
Module: dkong_sfx_mixer

Interface
REQ-001 Parameter WALK_HALF_PERIOD, default 32, walk square half-period in sample ticks.
REQ-002 Parameter JUMP_HALF_PERIOD, default 12, jump square half-period in sample ticks.
REQ-003 Parameter WALK_DECAY_DIV / JUMP_DECAY_DIV / CRASH_DECAY_DIV, defaults 16 / 64 / 128, sample ticks per envelope decrement.
REQ-004 soundclk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low; clock soundclk.
REQ-006 sample_tick  in  1  one-cycle sample-rate strobe.
REQ-007 dac_in  in  8  unsigned sound-CPU DAC code, 0x80 = silence.
REQ-008 dac_mute  in  1  1 = DAC contribution forced to 0.
REQ-009 walk_in, jump_in, crash_in  in  1 each  analog-SFX trigger levels; rising edge starts the sound.
REQ-010 noise_in  in  1  noise bit from sound block LFSR.
REQ-011 sample_out  out  16  signed mixed sample.
REQ-012 sample_valid  out  1  sample_out holds an unconsumed sample.
REQ-013 sample_ready  in  1  consumer accepts when sample_valid && sample_ready.
REQ-014 overrun  out  1  sticky; a sample was overwritten before acceptance.

Function
REQ-015 Each channel SHALL have FSM IDLE/PLAY, 8-bit envelope env, decay counter, half-period counter, square bit sq.
REQ-016 Rising edge on a trigger (prev=0, now=1, checked every soundclk) SHALL set env=255, decay and half-period counters=0, sq=1, state=PLAY, in any state (retrigger restarts).
REQ-017 In PLAY, on sample_tick: decay counter SHALL increment; at DECAY_DIV-1 it SHALL wrap to 0 and env SHALL decrement by 1.
REQ-018 env reaching 0 SHALL move state to IDLE; IDLE contribution is 0 and counters hold.
REQ-019 Walk/jump, on sample_tick in PLAY: half-period counter at HALF_PERIOD-1 SHALL wrap to 0 and toggle sq.
REQ-020 Crash SHALL use noise_in sampled at sample_tick in place of sq.
REQ-021 Channel contribution SHALL be signed 9-bit: +env if sq/noise=1, -env otherwise.
REQ-022 Trigger edge coincident with sample_tick: trigger wins, no decay or toggle that tick.
REQ-023 DAC term SHALL be (dac_in - 128) signed 9-bit, 0 when dac_mute=1.
REQ-024 Mix SHALL be (dac<<7) + (walk<<4) + (jump<<4) + (crash<<5), signed 16-bit; range -32704..32576, no saturation.
REQ-025 Latency: channel state updated at sample_tick cycle T; mix registered T+1; sample_out/sample_valid=1 at T+2.
REQ-026 sample_valid SHALL stay 1 with sample_out stable until accepted; on accept it clears next cycle unless a new sample loads that cycle.
REQ-027 New sample loading while sample_valid=1 and not accepted that cycle SHALL overwrite sample_out and set overrun=1.
REQ-028 sample_tick on consecutive cycles SHALL each produce one sample (pipeline fully pipelined).

Reset
REQ-029 rst_n=0 SHALL give: sample_out=0, sample_valid=0, overrun=0, all FSMs IDLE, env/counters/sq=0, mix pipeline cleared.
REQ-030 Trigger-history registers SHALL reset to 1; a trigger held high through reset SHALL NOT start a sound.
REQ-031 Reset mid-sound SHALL silence all channels immediately and drop any pending sample.

Structure
REQ-032 Package dkong_sound_pkg SHALL hold the channel state enum, SAMPLE_W=16, ENV_W=8 and mix shift constants.
REQ-033 Sub-module dkong_sfx_channel (edge detect, FSM, envelope, oscillator, noise select) SHALL be instantiated three times.

Verification
REQ-034 Idle, dac_in=0xFF, mute=0, one sample_tick -> sample_out=0x3F80 at T+2, sample_valid=1.
REQ-035 walk_in rise, dac_in=0x80, ticks: first sample=+4080 (0x0FF0); sign flips after 32 ticks; env=254 after 16 ticks; IDLE after 255*16 ticks.
REQ-036 All channels env=255, dac_in=0xFF, sq=1, noise=1 -> 32576; dac_in=0x00, sq=0, noise=0 -> -32704.
REQ-037 sample_ready=0 across two sample_ticks -> second sample overwrites, overrun=1 and stays 1 after ready returns.
REQ-038 jump_in high before and through reset release -> no sound; jump_in 0->1 coinciding with sample_tick -> env=255, decay counter=0.
REQ-039 rst_n=0 mid-crash -> next cycle all outputs 0, crash IDLE.
